// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if
// Bundles every fetch-controller signal except clk/rst.
//   imem side : imem_addr, imem_rmask (to memory), imem_rdata, imem_resp (from memory)
//   br_pred   : br_taken (combinational prediction for imem_addr + 4*i)
//   ROB       : flush, flush_pc
//   IQ side   : iq_valid, iq_slot_mask, iq_instr, iq_pc, iq_pred_taken (to queue), iq_ready (from queue)
// master = fetch controller, slave = the memory/predictor/ROB/queue environment.
interface fetch_pc_ctrl_if #(
    parameter int SS_FACTOR = 2
);
    logic [31:0]             imem_addr;
    logic [3:0]              imem_rmask;
    logic [32*SS_FACTOR-1:0] imem_rdata;
    logic                    imem_resp;
    logic [SS_FACTOR-1:0]    br_taken;
    logic                    flush;
    logic [31:0]             flush_pc;
    logic                    iq_valid;
    logic                    iq_ready;
    logic [SS_FACTOR-1:0]    iq_slot_mask;
    logic [32*SS_FACTOR-1:0] iq_instr;
    logic [32*SS_FACTOR-1:0] iq_pc;
    logic [SS_FACTOR-1:0]    iq_pred_taken;

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        input  br_taken,
        input  flush, flush_pc,
        output iq_valid, iq_slot_mask, iq_instr, iq_pc, iq_pred_taken,
        input  iq_ready
    );

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        output br_taken,
        output flush, flush_pc,
        input  iq_valid, iq_slot_mask, iq_instr, iq_pc, iq_pred_taken,
        output iq_ready
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Fetch-stage PC controller. Issues one imem request per fetch group,
// latches the branch prediction at request time, pre-decodes the returned
// group for predicted-taken branches and JALs, redirects the fetch PC, and
// presents a masked, annotated group to the instruction queue.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - fetch_pc_ctrl_if.master (imem request/response, br_taken,
//          flush/flush_pc, instruction-queue handshake and payload)
module fetch_pc_ctrl #(
    parameter int          SS_FACTOR = 2,
    parameter logic [31:0] RESET_PC  = 32'h1eceb000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_ctrl_if.master bus
);
    localparam logic [1:0] SEND  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [1:0]              state_reg;
    logic [31:0]             pc_reg;
    logic [SS_FACTOR-1:0]    pred_q_reg;
    logic                    out_valid_reg;
    logic [SS_FACTOR-1:0]    out_mask_reg;
    logic [32*SS_FACTOR-1:0] out_instr_reg;
    logic [32*SS_FACTOR-1:0] out_pc_reg;
    logic [SS_FACTOR-1:0]    out_pred_reg;

    // Per-slot pre-decode of the returned group.
    logic [SS_FACTOR-1:0]    slot_hit;
    logic [31:0]             slot_target [SS_FACTOR];
    logic [32*SS_FACTOR-1:0] slot_pc_flat;

    for (genvar gi = 0; gi < SS_FACTOR; gi++) begin : g_slot
        logic [31:0] instr;
        logic [31:0] slot_pc;
        logic [31:0] b_imm;
        logic [31:0] j_imm;
        logic        is_br;
        logic        is_jal;

        assign instr   = bus.imem_rdata[32*gi +: 32];
        assign slot_pc = pc_reg + 32'(4 * gi);
        assign b_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        assign j_imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        assign is_br   = (instr[6:0] == OP_BRANCH);
        assign is_jal  = (instr[6:0] == OP_JAL);

        // Branch redirects only if predicted taken when the request went out.
        assign slot_hit[gi]            = is_jal || (is_br && pred_q_reg[gi]);
        assign slot_target[gi]         = slot_pc + (is_jal ? j_imm : b_imm);
        assign slot_pc_flat[32*gi +: 32] = slot_pc;
    end

    // Lowest redirecting slot wins; slots above it are squashed.
    logic                 redirect_found;
    logic [SS_FACTOR-1:0] dec_mask;
    logic [SS_FACTOR-1:0] dec_pred;
    logic [31:0]          dec_next_pc;

    always_comb begin
        redirect_found = 1'b0;
        dec_mask       = '0;
        dec_pred       = '0;
        dec_next_pc    = pc_reg + 32'(4 * SS_FACTOR);
        for (int i = 0; i < SS_FACTOR; i++) begin
            dec_mask[i] = !redirect_found;
            if (!redirect_found && slot_hit[i]) begin
                redirect_found = 1'b1;
                dec_pred[i]    = 1'b1;
                dec_next_pc    = slot_target[i];
            end
        end
    end

    // A flush in SEND suppresses the request so nothing is left outstanding.
    assign bus.imem_addr     = pc_reg;
    assign bus.imem_rmask    = (state_reg == SEND && !bus.flush) ? 4'hF : 4'h0;
    assign bus.iq_valid      = out_valid_reg;
    assign bus.iq_slot_mask  = out_mask_reg;
    assign bus.iq_instr      = out_instr_reg;
    assign bus.iq_pc         = out_pc_reg;
    assign bus.iq_pred_taken = out_pred_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SEND;
            pc_reg        <= RESET_PC;
            pred_q_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_mask_reg  <= '0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
            out_pred_reg  <= '0;
        end else begin
            case (state_reg)
                SEND: begin
                    if (bus.flush) begin
                        pc_reg        <= bus.flush_pc & 32'hFFFF_FFFC;
                        out_valid_reg <= 1'b0;
                        state_reg     <= SEND;
                    end else begin
                        pred_q_reg <= bus.br_taken;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        // Response in the same cycle is simply discarded.
                        pc_reg    <= bus.flush_pc & 32'hFFFF_FFFC;
                        state_reg <= bus.imem_resp ? SEND : DRAIN;
                    end else if (bus.imem_resp) begin
                        out_valid_reg <= 1'b1;
                        out_mask_reg  <= dec_mask;
                        out_instr_reg <= bus.imem_rdata;
                        out_pc_reg    <= slot_pc_flat;
                        out_pred_reg  <= dec_pred;
                        pc_reg        <= dec_next_pc;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    // Flush beats a simultaneous iq_ready: the group is dropped.
                    if (bus.flush) begin
                        pc_reg        <= bus.flush_pc & 32'hFFFF_FFFC;
                        out_valid_reg <= 1'b0;
                        state_reg     <= SEND;
                    end else if (bus.iq_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= SEND;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        pc_reg <= bus.flush_pc & 32'hFFFF_FFFC;
                    end
                    if (bus.imem_resp) begin
                        state_reg <= SEND;
                    end
                end
                default: state_reg <= SEND;
            endcase
        end
    end
endmodule
